bus_grant_sequencer: RTL
========================

Name: bus_grant_sequencer

Overview:
- Upstream stage of the 32-to-5 bus-select encoder.
- Collects bus-drive requests from the 32 datapath sources (registers, HI/LO, Z, PC, MDR, in-port, C) and issues exactly one registered one-hot grant at a time.
- Arbitration is round-robin. The grant vector feeds the encoder directly, so the encoder never sees more than one bit set.

Parameters:
- WIDTH, 32, number of bus sources; one-hot vector width.
- HOLD_CYCLES, 1, minimum cycles a grant stays asserted before advance is honoured (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous active-low reset.
- req_in  input  WIDTH  request bits, sampled only when req_load=1.
- req_load  input  1  on the rising edge: pending <= pending | req_in.
- advance  input  1  downstream has consumed the current bus value; release the current grant.
- flush  input  1  synchronous: drop all pending requests and the current grant.
- grant_out  output  WIDTH  registered one-hot grant (all zero when idle) to the encoder.
- grant_valid  output  1  high when grant_out has exactly one bit set.
- pend_cnt  output  6  popcount of the pending register, registered.
- early_adv  output  1  sticky flag: advance arrived before HOLD_CYCLES elapsed; cleared by clr or flush.

Behaviour:
- Reset (clr=0, asynchronous):
  - pending, grant_out, ptr, hold_cnt, pend_cnt and early_adv all go to 0; grant_valid=0.
  - State goes to IDLE.
  - Reset asserted mid-grant drops the grant immediately, without waiting for a clock edge.
- Internal state:
  - pending[WIDTH-1:0]: queued requests.
  - ptr[4:0]: round-robin start index.
  - hold_cnt[3:0]: cycles the current grant has been held.
  - fsm: IDLE or GRANT.
- Selection function pick(mask, ptr): the lowest index i, searching ptr, ptr+1, …, WIDTH-1, 0, …, ptr-1 (modulo wrap), such that mask[i]=1.
- IDLE:
  - grant_out=0, grant_valid=0.
  - If the registered pending is nonzero at a clock edge: go to GRANT, grant_out <= onehot(pick(pending, ptr)), hold_cnt <= 0.
  - A req_load on the same edge updates pending only; it does not take part in that edge's pick.
  - Latency: req_load sampled at edge k -> grant_valid high after edge k+1.
  - advance in IDLE is ignored.
- GRANT:
  - grant_valid=1; grant_out is held stable; hold_cnt saturates at 15.
  - advance with hold_cnt < HOLD_CYCLES-1 is ignored and sets early_adv.
  - advance with hold_cnt >= HOLD_CYCLES-1 is accepted. On acceptance, at the same edge, with g = index of the current grant:
    - next_mask = (pending & ~onehot(g)) | (req_load ? req_in : 0). A re-request of g in the same cycle is therefore re-queued, not lost.
    - pending <= next_mask.
    - ptr <= (g+1) mod WIDTH.
    - If next_mask != 0: stay in GRANT, grant_out <= onehot(pick(next_mask, (g+1) mod WIDTH)), hold_cnt <= 0. This is a back-to-back grant with no idle bubble.
    - Otherwise: go to IDLE, grant_out <= 0.
- The granted bit stays set in pending until its grant is accepted.
- pend_cnt reflects pending as updated at the same edge.
- Wrap-around: g=WIDTH-1 gives ptr=0.
- flush:
  - Highest priority after reset; overrides advance and req_load in the same cycle.
  - pending <= 0, grant_out <= 0, go to IDLE, early_adv <= 0.
  - ptr is retained.
- Invariants:
  - grant_out is always zero or one-hot.
  - grant_valid == |grant_out.
  - No combinational path from any input to any output.

Test Plan:
- Reset then single request: release clr; req_load=1, req_in=0x0000_0010 at edge 1 -> grant_out=0x0000_0010 and grant_valid=1 after edge 2; pend_cnt=1; advance at edge 3 -> grant_out=0, IDLE, ptr=5.
- Round-robin wrap: ptr=30 (set by granting and accepting bit 29), load 0x8000_0003 -> grants in order bit31, bit0, bit1, back-to-back, one per accepted advance; then IDLE with pend_cnt=0.
- Simultaneous advance + req_load of the same bit: granted bit 5, req_in=0x20 with advance -> bit 5 stays pending; with no other requests it is re-granted next; pend_cnt stays 1.
- HOLD_CYCLES=3: grant bit 2; advance pulsed at hold_cnt=0 -> ignored, early_adv=1, grant held; advance at hold_cnt=2 -> accepted.
- Flush mid-grant: pending=0x0000_0F00, bit 8 granted; flush=1 together with advance and req_load=0x1 -> grant_out=0, pending=0, pend_cnt=0, early_adv=0; ptr unchanged (8).
- Async reset mid-grant: grant_out=0x0001_0000, pull clr low between edges -> grant_out=0 immediately, before the next edge; all state zero.

Source files
------------

// File: rtl/bus_grant_sequencer.sv
// Round-robin bus-drive arbiter: queues source requests and issues one registered
// one-hot grant at a time to the 32-to-5 bus-select encoder.
module bus_grant_sequencer #(
    parameter int WIDTH       = 32,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] req_in,
    input  logic             req_load,
    input  logic             advance,
    input  logic             flush,
    output logic [WIDTH-1:0] grant_out,
    output logic             grant_valid,
    output logic [5:0]       pend_cnt,
    output logic             early_adv
);

    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;
    localparam logic [3:0] HOLD_MIN = 4'(HOLD_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] grant_q, grant_d;
    logic [PW-1:0]    gidx_q, gidx_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [3:0]       hold_q, hold_d;
    logic [5:0]       pend_cnt_q, pend_cnt_d;
    logic             early_q, early_d;

    logic [WIDTH-1:0] load_mask, next_mask, pick_mask;
    logic [PW-1:0]    after_g, pick_start, pick_idx;
    logic             pick_found, accept;

    assign load_mask = req_load ? req_in : '0;
    assign next_mask = (pending_q & ~grant_q) | load_mask;
    assign after_g   = (int'(gidx_q) == WIDTH - 1) ? '0 : gidx_q + 1'b1;
    assign accept    = (state_q == S_GRANT) && advance && (hold_q >= HOLD_MIN);

    // One shared picker: IDLE searches registered pending from ptr, GRANT searches
    // the post-acceptance mask from just past the current grant.
    assign pick_mask  = (state_q == S_IDLE) ? pending_q : next_mask;
    assign pick_start = (state_q == S_IDLE) ? ptr_q : after_g;

    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int k = 0; k < WIDTH; k++) begin
            idx = (int'(pick_start) + k) % WIDTH;
            if (!pick_found && pick_mask[idx]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        early_d   = early_q;
        if (flush) begin
            state_d   = S_IDLE;
            pending_d = '0;
            grant_d   = '0;
            hold_d    = '0;
            early_d   = 1'b0;
        end else if (state_q == S_IDLE) begin
            pending_d = pending_q | load_mask;
            hold_d    = '0;
            if (pending_q != '0) begin
                state_d           = S_GRANT;
                grant_d           = '0;
                grant_d[pick_idx] = 1'b1;
                gidx_d            = pick_idx;
            end
        end else if (accept) begin
            pending_d = next_mask;
            ptr_d     = after_g;
            hold_d    = '0;
            grant_d   = '0;
            if (pick_found) begin
                grant_d[pick_idx] = 1'b1;
                gidx_d            = pick_idx;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            pending_d = pending_q | load_mask;
            if (hold_q != 4'hF) begin
                hold_d = hold_q + 4'd1;
            end
            if (advance) begin
                early_d = 1'b1;
            end
        end
        pend_cnt_d = 6'($countones(pending_d));
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            grant_q    <= '0;
            gidx_q     <= '0;
            ptr_q      <= '0;
            hold_q     <= '0;
            pend_cnt_q <= '0;
            early_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            pend_cnt_q <= pend_cnt_d;
            early_q    <= early_d;
        end
    end

    assign grant_out   = grant_q;
    assign grant_valid = |grant_q;
    assign pend_cnt    = pend_cnt_q;
    assign early_adv   = early_q;

endmodule
